// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S mono transmitter with frame-request pulse
//
// Generates bclk/lrclk timing from clk, asks the sample source for a new word
// once per frame, and shifts the latched word out MSB first with the
// one-bit I2S delay. The same mono word is sent in the left and right channels.
//
// Ports:
//   i_clk        system clock, rising-edge logic
//   i_reset      asynchronous active-low reset
//   i_sample     signed PCM sample, captured only at a frame boundary
//   i_play       1 = send i_sample, 0 = send a zero word
//   o_new_frame  one-clk pulse at each frame boundary (request next sample)
//   o_bclk       bit clock, period 2*CLK_DIV clk, 50% duty
//   o_lrclk      word select: 0 = left slots, 1 = right slots
//   o_sdata      serial data
module i2s_audio_tx #(
   parameter int CLK_DIV  = 32,
   parameter int SAMPLE_W = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [SAMPLE_W-1:0] i_sample,
   input  logic                i_play,
   output logic                o_new_frame,
   output logic                o_bclk,
   output logic                o_lrclk,
   output logic                o_sdata
);

   localparam int SLOTS  = 2 * SAMPLE_W;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLOT_W = $clog2(SLOTS);

   logic [DIV_W-1:0]    r_div_cnt;
   logic [SLOT_W-1:0]   r_slot;
   logic                r_bclk;
   logic                r_lrclk;
   logic                r_sdata;
   logic                r_new_frame;
   logic [SLOTS-1:0]    r_shift;

   logic                w_tick;
   logic                w_fe;
   logic                w_wrap;
   logic [SLOT_W-1:0]   w_slot_next;
   logic [SAMPLE_W-1:0] w_word;

   assign w_tick      = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   // Falling edge of bclk: the divider expires while bclk is currently high.
   assign w_fe        = w_tick & r_bclk;
   assign w_wrap      = (r_slot == SLOT_W'(SLOTS - 1));
   assign w_slot_next = w_wrap ? '0 : r_slot + 1'b1;
   assign w_word      = i_play ? i_sample : '0;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_div_cnt   <= '0;
         r_slot      <= '0;
         r_bclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_new_frame <= 1'b0;
         r_shift     <= '0;
      end else begin
         r_new_frame <= 1'b0;
         if (w_tick) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
         if (w_fe) begin
            r_slot  <= w_slot_next;
            r_lrclk <= (w_slot_next >= SLOT_W'(SAMPLE_W));
            // The delay flop takes the MSB each slot; at the boundary that is
            // the previous frame's last bit, which gives the I2S one-bit delay.
            r_sdata <= r_shift[SLOTS-1];
            if (w_wrap) begin
               r_shift     <= {w_word, w_word};
               r_new_frame <= 1'b1;
            end else begin
               r_shift <= {r_shift[SLOTS-2:0], 1'b0};
            end
         end
      end
   end

   assign o_new_frame = r_new_frame;
   assign o_bclk      = r_bclk;
   assign o_lrclk     = r_lrclk;
   assign o_sdata     = r_sdata;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

   logic        clk;
   logic        reset;
   logic [15:0] sample;
   logic        play;
   logic        new_frame;
   logic        bclk;
   logic        lrclk;
   logic        sdata;

   int n_cmp = 0;
   int n_bad = 0;

   i2s_audio_tx #(.CLK_DIV(2), .SAMPLE_W(16)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_sample    (sample),
      .i_play      (play),
      .o_new_frame (new_frame),
      .o_bclk      (bclk),
      .o_lrclk     (lrclk),
      .o_sdata     (sdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse reset and release it on a falling clk edge; afterwards each
   // @(negedge clk) shows the state after one more rising edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_frame(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (new_frame === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: new_frame not seen within 400 clks, required a pulse", name);
      end
   endtask

   // Captures sdata of one frame: bits[31-k] = slot k. At slot chg_slot the
   // sample/play inputs are changed to exercise mid-frame isolation.
   task automatic capture_frame(input string name, input int chg_slot,
                                input logic [15:0] chg_sample, input logic chg_play,
                                output logic [31:0] bits);
      bit ok;
      bits = '0;
      wait_frame(name, ok);
      if (ok) begin
         for (int k = 0; k < 32; k++) begin
            if (k != 0) repeat (4) @(negedge clk);
            bits[31-k] = sdata;
            if (k == chg_slot) begin
               sample = chg_sample;
               play   = chg_play;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      sample = 16'h0000;
      play   = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++; if (bclk !== 1'b0)      begin n_bad++; $display("FAIL rst_bclk: got %b want 0", bclk); end
      n_cmp++; if (lrclk !== 1'b0)     begin n_bad++; $display("FAIL rst_lrclk: got %b want 0", lrclk); end
      n_cmp++; if (sdata !== 1'b0)     begin n_bad++; $display("FAIL rst_sdata: got %b want 0", sdata); end
      n_cmp++; if (new_frame !== 1'b0) begin n_bad++; $display("FAIL rst_new_frame: got %b want 0", new_frame); end
      reset = 1'b1;
      // bclk after edges 1..6 after release: 0 1 1 0 0 1
      for (int e = 1; e <= 6; e++) begin
         logic exp;
         @(negedge clk);
         exp = (e == 2 || e == 3 || e == 6);
         n_cmp++;
         if (bclk !== exp) begin
            n_bad++;
            $display("FAIL bclk_edge%0d: got %b want %b", e, bclk, exp);
         end
      end
   endtask

   task automatic test_frame_timing();
      int first_nf, second_nf, pulses;
      logic lr63, lr64, lr127, lr128;
      first_nf = -1; second_nf = -1; pulses = 0;
      lr63 = 1'bx; lr64 = 1'bx; lr127 = 1'bx; lr128 = 1'bx;
      do_reset();
      for (int e = 1; e <= 300; e++) begin
         @(negedge clk);
         if (new_frame === 1'b1) begin
            pulses++;
            if (first_nf < 0) first_nf = e;
            else if (second_nf < 0) second_nf = e;
         end
         if (e == 63)  lr63  = lrclk;
         if (e == 64)  lr64  = lrclk;
         if (e == 127) lr127 = lrclk;
         if (e == 128) lr128 = lrclk;
      end
      n_cmp++; if (first_nf != 128)  begin n_bad++; $display("FAIL nf_first: got clk %0d want 128", first_nf); end
      n_cmp++; if (second_nf != 256) begin n_bad++; $display("FAIL nf_second: got clk %0d want 256", second_nf); end
      n_cmp++; if (pulses != 2)      begin n_bad++; $display("FAIL nf_width: got %0d high clks want 2", pulses); end
      n_cmp++; if (lr63 !== 1'b0)    begin n_bad++; $display("FAIL lrclk_63: got %b want 0", lr63); end
      n_cmp++; if (lr64 !== 1'b1)    begin n_bad++; $display("FAIL lrclk_64: got %b want 1", lr64); end
      n_cmp++; if (lr127 !== 1'b1)   begin n_bad++; $display("FAIL lrclk_127: got %b want 1", lr127); end
      n_cmp++; if (lr128 !== 1'b0)   begin n_bad++; $display("FAIL lrclk_128: got %b want 0", lr128); end
   endtask

   task automatic test_data_mute_midframe();
      logic [31:0] got;
      do_reset();
      sample = 16'hA5C3;
      play   = 1'b1;
      // Frame 1: A5C3, previous frame empty so slot 0 = 0.
      capture_frame("a5c3", 31, 16'h7FFF, 1'b0, got);
      n_cmp++;
      if (got !== {1'b0, 16'hA5C3, 15'h52E1}) begin
         n_bad++; $display("FAIL data_a5c3: got %h want %h", got, {1'b0, 16'hA5C3, 15'h52E1});
      end
      // Frame 2: muted (7FFF ignored); play=1 at slot 5 must not leak in.
      capture_frame("mute", 5, 16'h7FFF, 1'b1, got);
      n_cmp++;
      if (got !== 32'h8000_0000) begin
         n_bad++; $display("FAIL data_mute: got %h want 80000000", got);
      end
      // Frame 3: play now 1 -> 7FFF; load 1234 for the next boundary at slot 20.
      capture_frame("7fff", 20, 16'h1234, 1'b1, got);
      n_cmp++;
      if (got !== {1'b0, 16'h7FFF, 15'h3FFF}) begin
         n_bad++; $display("FAIL data_7fff: got %h want %h", got, {1'b0, 16'h7FFF, 15'h3FFF});
      end
      // Frame 4: 1234, sample changes to FFFF at slot 8 without effect.
      capture_frame("1234", 8, 16'hFFFF, 1'b1, got);
      n_cmp++;
      if (got !== {1'b1, 16'h1234, 15'h091A}) begin
         n_bad++; $display("FAIL data_1234: got %h want %h", got, {1'b1, 16'h1234, 15'h091A});
      end
      // Frame 5: FFFF still present at the boundary.
      capture_frame("ffff", 99, 16'hFFFF, 1'b1, got);
      n_cmp++;
      if (got !== {1'b0, 16'hFFFF, 15'h7FFF}) begin
         n_bad++; $display("FAIL data_ffff: got %h want %h", got, {1'b0, 16'hFFFF, 15'h7FFF});
      end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int nf_clk;
      bit nf_during;
      sample = 16'hFFFF;
      play   = 1'b1;
      do_reset();
      wait_frame("rstmid", ok);
      repeat (81) @(negedge clk);       // inside slot 20, frame carries FFFF
      n_cmp++; if (lrclk !== 1'b1) begin n_bad++; $display("FAIL pre_rst_lrclk: got %b want 1", lrclk); end
      n_cmp++; if (sdata !== 1'b1) begin n_bad++; $display("FAIL pre_rst_sdata: got %b want 1", sdata); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (lrclk !== 1'b0)     begin n_bad++; $display("FAIL async_lrclk: got %b want 0", lrclk); end
      n_cmp++; if (sdata !== 1'b0)     begin n_bad++; $display("FAIL async_sdata: got %b want 0", sdata); end
      n_cmp++; if (new_frame !== 1'b0) begin n_bad++; $display("FAIL async_new_frame: got %b want 0", new_frame); end
      nf_during = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (new_frame !== 1'b0 || bclk !== 1'b0) nf_during = 1'b1;
      end
      n_cmp++; if (nf_during) begin n_bad++; $display("FAIL rst_hold_quiet: got activity want none"); end
      reset = 1'b1;
      nf_clk = -1;
      for (int e = 1; e <= 400; e++) begin
         @(negedge clk);
         if (new_frame === 1'b1) begin
            nf_clk = e;
            break;
         end
      end
      n_cmp++; if (nf_clk != 128) begin n_bad++; $display("FAIL rst_restart_nf: got clk %0d want 128", nf_clk); end
   endtask

   initial begin
      test_reset();
      test_frame_timing();
      test_data_mute_midframe();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
